// File: rtl/nap_countdown_timer_pkg.sv
// ---------------------------------------------------------------------------
// nap_timer_pkg
// Shared definitions for the nap countdown timer:
//   - state_t      : FSM encoding (IDLE, RUN, PAUSE, ALARM)
//   - digit limits : largest legal value of each BCD digit position
//   - digits_valid : range check applied to a time entered on the keypad
// ---------------------------------------------------------------------------
package nap_timer_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [3:0] HOUR_TEN_MAX       = 4'd2;
   localparam logic [3:0] HOUR_ONE_MAX_AT_20 = 4'd3;
   localparam logic [3:0] TEN_MAX_MS         = 4'd5;
   localparam logic [3:0] ONE_MAX            = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      ALARM = 2'd3
   } state_t;

   // True when the six digits form a legal HH:MM:SS value (00:00:00..23:59:59).
   function automatic logic digits_valid(input logic [3:0] ht, input logic [3:0] ho,
                                         input logic [3:0] mt, input logic [3:0] mo,
                                         input logic [3:0] st, input logic [3:0] so);
      logic ok;
      ok = (ht <= HOUR_TEN_MAX) && (ho <= ONE_MAX) &&
           (mt <= TEN_MAX_MS)   && (mo <= ONE_MAX) &&
           (st <= TEN_MAX_MS)   && (so <= ONE_MAX);
      if ((ht == HOUR_TEN_MAX) && (ho > HOUR_ONE_MAX_AT_20))
         ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/nap_countdown_timer_if.sv
// ---------------------------------------------------------------------------
// nap_countdown_timer_if
// Bundles the timer's digit inputs, control pulses and status/digit outputs.
//   master : time-entry / control side (drives *_in and the pulses)
//   slave  : the timer itself (drives *_out, running, alarm, load_err)
// ---------------------------------------------------------------------------
interface nap_countdown_timer_if;
   import nap_timer_pkg::*;

   logic [DIGIT_W-1:0] hour_ten_in;
   logic [DIGIT_W-1:0] hour_one_in;
   logic [DIGIT_W-1:0] min_ten_in;
   logic [DIGIT_W-1:0] min_one_in;
   logic [DIGIT_W-1:0] sec_ten_in;
   logic [DIGIT_W-1:0] sec_one_in;
   logic               load;
   logic               start;
   logic               pause;
   logic               ack;

   logic [DIGIT_W-1:0] hour_ten_out;
   logic [DIGIT_W-1:0] hour_one_out;
   logic [DIGIT_W-1:0] min_ten_out;
   logic [DIGIT_W-1:0] min_one_out;
   logic [DIGIT_W-1:0] sec_ten_out;
   logic [DIGIT_W-1:0] sec_one_out;
   logic               running;
   logic               alarm;
   logic               load_err;

   modport master (
      output hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in,
      output load, start, pause, ack,
      input  hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out,
      input  running, alarm, load_err
   );

   modport slave (
      input  hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in,
      input  load, start, pause, ack,
      output hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out,
      output running, alarm, load_err
   );

endinterface

// File: rtl/nap_countdown_timer_bcd_pair_dec.sv
// ---------------------------------------------------------------------------
// bcd_pair_dec
// One two-digit BCD down-counter (tens:ones) used for hours, minutes and
// seconds. Loadable; decrements by one when dec is high.
//   clk, rst          : clock, async active-high reset (clears to 00)
//   load              : capture din_ten/din_one
//   din_ten, din_one  : digits to load
//   dec               : decrement request (tick or borrow from lower pair)
//   ten_max           : value the tens digit wraps to when borrowing past 00
//   ten, one          : current digits
//   borrow_out        : this pair wraps on this decrement; feeds next pair
//   is_zero           : pair currently reads 00
// ---------------------------------------------------------------------------
module bcd_pair_dec
   import nap_timer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] din_ten,
   input  logic [3:0] din_one,
   input  logic       dec,
   input  logic [3:0] ten_max,
   output logic [3:0] ten,
   output logic [3:0] one,
   output logic       borrow_out,
   output logic       is_zero
);

   assign is_zero    = (ten == 4'd0) && (one == 4'd0);
   assign borrow_out = dec && is_zero;

   // Ones digit underflows to 9 and pulls one from the tens digit; the tens
   // digit underflows to ten_max and the borrow escapes to the next pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ten <= 4'd0;
         one <= 4'd0;
      end else if (load) begin
         ten <= din_ten;
         one <= din_one;
      end else if (dec) begin
         if (one == 4'd0) begin
            one <= ONE_MAX;
            ten <= (ten == 4'd0) ? ten_max : ten - 4'd1;
         end else begin
            one <= one - 4'd1;
         end
      end
   end

endmodule

// File: rtl/nap_countdown_timer.sv
// ---------------------------------------------------------------------------
// nap_countdown_timer
// Loads a validated HH:MM:SS value from the keypad stage and counts it down
// once per second, raising a sticky alarm at 00:00:00 until acknowledged.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   bus      : nap_countdown_timer_if.slave
//              in : six BCD digits, load/start/pause/ack pulses
//              out: six BCD digits of remaining time, running, alarm,
//                   load_err (one-cycle pulse on a rejected load)
// Parameters:
//   TICK_DIV : clk cycles per one-second tick (>= 2)
//   CNT_W    : prescaler width, 2**CNT_W >= TICK_DIV
// ---------------------------------------------------------------------------
module nap_countdown_timer
   import nap_timer_pkg::*;
#(
   parameter int TICK_DIV = 1000,
   parameter int CNT_W    = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   nap_countdown_timer_if.slave  bus
);

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] prescaler;
   logic             tick;
   logic             load_en;
   logic             clear_pre;
   logic             err_next;
   logic             load_err_q;
   logic             load_valid;

   logic       sec_borrow, min_borrow, hour_borrow;
   logic       sec_zero, min_zero, hour_zero;
   logic       count_zero;
   logic       count_one;

   assign load_valid = digits_valid(bus.hour_ten_in, bus.hour_one_in,
                                    bus.min_ten_in,  bus.min_one_in,
                                    bus.sec_ten_in,  bus.sec_one_in);

   assign tick       = (state == RUN) && (prescaler == TICK_LAST);
   assign count_zero = hour_zero && min_zero && sec_zero;
   // 00:00:01 is the value whose next tick lands on zero.
   assign count_one  = hour_zero && min_zero &&
                       (bus.sec_ten_out == 4'd0) && (bus.sec_one_out == 4'd1);

   // Seconds decrement on the tick; each higher pair on the borrow below it.
   bcd_pair_dec u_sec (
      .clk        (clk),
      .rst        (rst),
      .load       (load_en),
      .din_ten    (bus.sec_ten_in),
      .din_one    (bus.sec_one_in),
      .dec        (tick),
      .ten_max    (TEN_MAX_MS),
      .ten        (bus.sec_ten_out),
      .one        (bus.sec_one_out),
      .borrow_out (sec_borrow),
      .is_zero    (sec_zero)
   );

   bcd_pair_dec u_min (
      .clk        (clk),
      .rst        (rst),
      .load       (load_en),
      .din_ten    (bus.min_ten_in),
      .din_one    (bus.min_one_in),
      .dec        (sec_borrow),
      .ten_max    (TEN_MAX_MS),
      .ten        (bus.min_ten_out),
      .one        (bus.min_one_out),
      .borrow_out (min_borrow),
      .is_zero    (min_zero)
   );

   // Hours never borrow past 00 because the count stops at zero, so the
   // top-level borrow is left dangling.
   bcd_pair_dec u_hour (
      .clk        (clk),
      .rst        (rst),
      .load       (load_en),
      .din_ten    (bus.hour_ten_in),
      .din_one    (bus.hour_one_in),
      .dec        (min_borrow),
      .ten_max    (HOUR_TEN_MAX),
      .ten        (bus.hour_ten_out),
      .one        (bus.hour_one_out),
      .borrow_out (hour_borrow),
      .is_zero    (hour_zero)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic. Pulses are resolved in the order ack > load > pause >
   // start; the highest-priority pulse present consumes the cycle. Reaching
   // zero on a tick overrides any pulse seen in RUN.
   always_comb begin
      next_state = state;
      load_en    = 1'b0;
      clear_pre  = 1'b0;
      err_next   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ack) begin
            end else if (bus.load) begin
               if (load_valid)
                  load_en = 1'b1;
               else
                  err_next = 1'b1;
            end else if (bus.pause) begin
            end else if (bus.start && !count_zero) begin
               next_state = RUN;
               clear_pre  = 1'b1;
            end
         end
         RUN: begin
            if (tick && count_one)
               next_state = ALARM;
            else if (bus.ack) begin
            end else if (bus.load)
               err_next = 1'b1;
            else if (bus.pause)
               next_state = PAUSE;
         end
         PAUSE: begin
            if (bus.ack) begin
            end else if (bus.load)
               err_next = 1'b1;
            else if (bus.pause) begin
            end else if (bus.start)
               next_state = RUN;
         end
         ALARM: begin
            if (bus.ack)
               next_state = IDLE;
            else if (bus.load)
               err_next = 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

   // Prescaler advances on every RUN cycle, including the cycle a pause is
   // accepted, and is held in PAUSE so a resume finishes the partial second.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         prescaler <= '0;
      else if (clear_pre)
         prescaler <= '0;
      else if (state == RUN)
         prescaler <= tick ? '0 : prescaler + CNT_W'(1);
   end

   // Rejected-load flag is registered so it appears as a clean one-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         load_err_q <= 1'b0;
      else
         load_err_q <= err_next;
   end

   assign bus.running  = (state == RUN);
   assign bus.alarm    = (state == ALARM);
   assign bus.load_err = load_err_q;

endmodule
